// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response encodings and master adapter FSM states.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } m_state_e;

  // True when the captured response reports an error (SLVERR or DECERR).
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi4_lite_master_adapter.sv
// AXI4-Lite initiator: turns one client request at a time into an AW+W->B write
// or an AR->R read and returns the captured response on a held client port.
module axi4_lite_master_adapter
  import axi4_lite_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 12,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8,
  parameter logic [AXI_ID_WIDTH-1:0] TXN_ID = '0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // client request port
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
  input  logic [AXI_BYTE_COUNT-1:0] req_wstrb,
  input  logic [2:0]                req_prot,
  // client response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_err,
  // AXI AW
  output logic [AXI_ID_WIDTH-1:0]   awid,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  // AXI W
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic [AXI_BYTE_COUNT-1:0] wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  // AXI B
  input  logic [AXI_ID_WIDTH-1:0]   bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  // AXI AR
  output logic [AXI_ID_WIDTH-1:0]   arid,
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  // AXI R
  input  logic [AXI_ID_WIDTH-1:0]   rid,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  m_state_e                  state_q;

  // one-deep capture of the client request
  logic                      write_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_BYTE_COUNT-1:0] wstrb_q;
  logic [2:0]                prot_q;

  // write-phase handshake tracking
  logic                      aw_done_q;
  logic                      w_done_q;

  // registered handshake outputs
  logic                      req_ready_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic                      rsp_valid_q;

  // captured response
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]                rsp_resp_q;

  // handshakes completing this cycle
  logic                      aw_hs;
  logic                      w_hs;
  logic                      aw_fin;
  logic                      w_fin;

  // IDs from the response channels carry no information with a single constant ID
  logic                      unused_ids;

  assign unused_ids = ^{bid, rid};

  // Write-phase completion, counting handshakes that land in this cycle.
  always_comb begin
    aw_hs  = awvalid_q & awready;
    w_hs   = wvalid_q & wready;
    aw_fin = aw_done_q | aw_hs;
    w_fin  = w_done_q | w_hs;
  end

  // Transaction FSM; every handshake output is a register updated with the state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      req_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            prot_q      <= req_prot;
            req_ready_q <= 1'b0;
            if (req_write) begin
              state_q   <= WR_REQ;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_REQ;
              arvalid_q <= 1'b1;
            end
          end
        end

        WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            rsp_resp_q  <= bresp;
            rsp_rdata_q <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end

        RD_REQ: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (rvalid) begin
            rsp_rdata_q <= rdata;
            rsp_resp_q  <= rresp;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_err   = resp_is_err(rsp_resp_q);

  assign awid    = TXN_ID;
  assign awaddr  = addr_q;
  assign awprot  = prot_q;
  assign awvalid = awvalid_q;

  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wvalid = wvalid_q;

  assign bready = bready_q;

  assign arid    = TXN_ID;
  assign araddr  = addr_q;
  assign arprot  = prot_q;
  assign arvalid = arvalid_q;

  assign rready = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_adapter.sv
// Directed bench for the AXI4-Lite master adapter with a response scoreboard.
module tb_axi4_lite_master_adapter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [0:0]  awid, arid, bid, rid;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[logic [11:0]];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          t_first, t_second;

  axi4_lite_master_adapter #(
    .AXI_ID_WIDTH  (1),
    .AXI_ADDR_WIDTH(12),
    .AXI_DATA_WIDTH(32),
    .AXI_BYTE_COUNT(4),
    .TXN_ID        (1'b0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_err(rsp_err),
    .awid(awid), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request in the current cycle (req_ready must be high), move to N+1.
  task automatic issue(input string tag, input logic w, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                       input logic push, input exp_t e);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_prot  = p;
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    if (push) sb.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  // Compare the presented response against the oldest expectation.
  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_write"}, rsp_write, e.w);
      chk({tag, "_rsp_rdata"}, rsp_rdata, e.d);
      chk({tag, "_rsp_resp"},  rsp_resp,  e.r);
      chk({tag, "_rsp_err"},   rsp_err,   e.r[1]);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_timeout"}, rsp_valid, 1'b1);
  endtask

  initial begin
    aresetn = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_prot = '0;
    rsp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    arready = 0; rvalid = 0; rresp = '0; rdata = '0; rid = '0;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_valids", {rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 6'b0);
    chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 35'b0);
    aresetn = 1'b1;
    tick();
    chk("post_rst_req_ready", req_ready, 1'b1);

    // ---- write, zero-wait ----
    issue("wr0", 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b010, 1'b1, '{1'b1, 32'h0, 2'b00});
    chk("wr0_valids_n1", {awvalid, wvalid}, 2'b11);
    chk("wr0_awaddr", awaddr, 12'h010);
    chk("wr0_wdata", wdata, 32'hDEADBEEF);
    chk("wr0_awprot", awprot, 3'd2);
    chk("wr0_wstrb_awid", {wstrb, awid}, {4'hF, 1'b0});
    awready = 1; wready = 1;
    mem[12'h010] = 32'hDEADBEEF;
    tick(); // N+2
    awready = 0; wready = 0;
    chk("wr0_bready_n2", {bready, awvalid, wvalid}, 3'b100);
    bvalid = 1; bresp = 2'b00;
    tick(); // N+3
    bvalid = 0;
    chk("wr0_rsp_valid_n3", rsp_valid, 1'b1);
    sb_check("wr0");
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("wr0_idle", {req_ready, rsp_valid}, 2'b10);

    // ---- staggered write: AW at N+1, W at N+4 ----
    issue("wr1", 1'b1, 12'h014, 32'hA5A50000, 4'h3, 3'b000, 1'b1, '{1'b1, 32'h0, 2'b00});
    chk("wr1_valids_n1", {awvalid, wvalid}, 2'b11);
    awready = 1;
    tick(); // N+2
    awready = 0;
    chk("wr1_aw_drop_n2", {awvalid, wvalid, bready}, 3'b010);
    tick(); // N+3
    chk("wr1_w_hold_n3", {awvalid, wvalid, bready}, 3'b010);
    tick(); // N+4
    chk("wr1_w_hold_n4", {awvalid, wvalid, bready, wdata}, {3'b010, 32'hA5A50000});
    wready = 1;
    mem[12'h014] = 32'hA5A50000;
    tick(); // N+5
    wready = 0;
    chk("wr1_bready_n5", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("wr1_rsp_valid", rsp_valid, 1'b1);
    sb_check("wr1");
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // ---- read with SLVERR, arready after 2 waits, then client backpressure ----
    issue("rd0", 1'b0, 12'h020, 32'h0, 4'h0, 3'b001, 1'b1, '{1'b0, 32'h12345678, 2'b10});
    chk("rd0_ar_n1", {arvalid, araddr, arprot, arid}, {1'b1, 12'h020, 3'b001, 1'b0});
    tick();
    chk("rd0_ar_wait1", {arvalid, rready}, 2'b10);
    tick();
    chk("rd0_ar_wait2", {arvalid, rready}, 2'b10);
    arready = 1;
    tick();
    arready = 0;
    chk("rd0_rready", {arvalid, rready}, 2'b01);
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b10;
    tick();
    rvalid = 0; rdata = '0; rresp = '0;
    chk("rd0_rsp_valid", {rsp_valid, rready}, 2'b10);
    // a competing request must not be accepted while the response is held
    req_valid = 1; req_write = 1; req_addr = 12'h0FF; req_wdata = 32'h11111111; req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, req_ready, rsp_err, rsp_resp, rsp_rdata, rsp_write},
          {1'b1, 1'b0, 1'b1, 2'b10, 32'h12345678, 1'b0});
      chk("bp_no_axi", {awvalid, wvalid, arvalid}, 3'b000);
      tick();
    end
    req_valid = 0;
    sb_check("rd0");
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("bp_release", {req_ready, rsp_valid, awvalid, arvalid}, 4'b1000);

    // ---- reset while AW/W are outstanding ----
    issue("rst_mid", 1'b1, 12'h030, 32'h55AA55AA, 4'hF, 3'b000, 1'b0, '{1'b0, 32'h0, 2'b00});
    chk("rst_mid_aw_up", {awvalid, wvalid}, 2'b11);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_mid_drop", {awvalid, wvalid, bready}, 3'b000);
    tick();
    aresetn = 1'b1;
    tick();
    chk("rst_mid_after", {req_ready, rsp_valid, awvalid, wvalid}, 4'b1000);
    tick();
    chk("rst_mid_no_rsp", rsp_valid, 1'b0);

    // ---- back-to-back write then read of 0x004, rsp_ready tied high ----
    rsp_ready = 1;
    t_first = cyc;
    issue("b2b_wr", 1'b1, 12'h004, 32'hCAFEF00D, 4'hF, 3'b000, 1'b1, '{1'b1, 32'h0, 2'b00});
    awready = 1; wready = 1;
    mem[12'h004] = 32'hCAFEF00D;
    tick();
    awready = 0; wready = 0;
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("b2b_wr_rsp_valid", rsp_valid, 1'b1);
    sb_check("b2b_wr");
    req_valid = 1; req_write = 0; req_addr = 12'h004; req_prot = 3'b000;
    begin
      int n = 0;
      while (!req_ready && n < 20) begin
        tick();
        n++;
      end
    end
    t_second = cyc;
    chk("b2b_spacing", t_second - t_first, 4);
    sb.push_back('{1'b0, 32'hCAFEF00D, 2'b00});
    tick();
    req_valid = 0;
    chk("b2b_rd_ar", {arvalid, araddr}, {1'b1, 12'h004});
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1;
    rdata = mem.exists(araddr) ? mem[araddr] : 32'h0;
    rresp = 2'b00;
    tick();
    rvalid = 0;
    wait_rsp("b2b_rd");
    sb_check("b2b_rd");
    tick();
    rsp_ready = 0;
    chk("sb_drained", sb.size(), 0);
    chk("final_idle", {req_ready, rsp_valid}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
